// File: rtl/seq_entry_checker_pkg.sv
// Shared types and constants for the button-entry checker.
// Debounce stage length applies only when SEQ_ENTRY_DEBOUNCE_EN is defined.
package seq_entry_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } collect_state_t;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/seq_entry_checker_if.sv
// Button inputs and status outputs of the entry checker, bundled for port use.
// The master side drives the buttons; the slave side is the checker itself.
interface seq_entry_checker_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             btn0_n;
    logic             btn1_n;
    logic             btn_entry_n;
    logic [WIDTH-1:0] pattern;
    logic [CW-1:0]    digit_count;
    logic [CW-1:0]    ones_count;
    logic             result_valid;
    logic             result_pass;
    logic             led_light;

    modport master (
        output btn0_n, btn1_n, btn_entry_n,
        input  pattern, digit_count, ones_count, result_valid, result_pass, led_light
    );

    modport slave (
        input  btn0_n, btn1_n, btn_entry_n,
        output pattern, digit_count, ones_count, result_valid, result_pass, led_light
    );

endinterface

// File: rtl/seq_entry_checker_btn_press_detect.sv
// Synchronises one active-low button and emits a one-cycle pulse per press.
// Optional debounce stage enabled by SEQ_ENTRY_DEBOUNCE_EN.
module btn_press_detect
    import seq_entry_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    output logic o_press
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_level;
    logic                   r_prev;
    logic                   r_press;

    // NOTE: synchroniser resets to the released level so reset exit never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_n};
        end
    end

`ifdef SEQ_ENTRY_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_stable;
    logic [DW-1:0] r_db_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= 1'b1;
            r_db_cnt <= '0;
        end else if (r_sync[SYNC_STAGES-1] == r_stable) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            r_stable <= r_sync[SYNC_STAGES-1];
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DW'(1);
        end
    end

    assign w_level = r_stable;
`else
    assign w_level = r_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_prev  <= w_level;
            r_press <= r_prev & ~w_level;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/seq_entry_checker.sv
// Binary-digit entry checker: shift window, digit count, popcount evaluation, LED hold.
// Define SEQ_ENTRY_DEBOUNCE_EN to debounce the button inputs.
module seq_entry_checker
    import seq_entry_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int MIN_ONES       = 2,
    parameter int HOLD_CYCLES    = 8,
    parameter int CLEAR_ON_ENTRY = 0
) (
    input logic                clk,
    input logic                rst,
    seq_entry_checker_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(HOLD_CYCLES + 1);

    logic           w_p0, w_p1, w_pe;
    logic           w_digit, w_bit, w_pass, w_clear;
    logic [CW-1:0]  w_ones;

    logic [WIDTH-1:0] r_pattern;
    logic [CW-1:0]    r_count;
    collect_state_t   r_state;
    logic             r_valid;
    logic             r_pass;
    logic [TW-1:0]    r_timer;

    btn_press_detect u_det0 (.clk(clk), .rst(rst), .i_btn_n(bus.btn0_n),      .o_press(w_p0));
    btn_press_detect u_det1 (.clk(clk), .rst(rst), .i_btn_n(bus.btn1_n),      .o_press(w_p1));
    btn_press_detect u_dete (.clk(clk), .rst(rst), .i_btn_n(bus.btn_entry_n), .o_press(w_pe));

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ones = w_ones + CW'(r_pattern[i]);
        end
    end

    // btn0 wins a same-cycle collision, so the shifted bit is 1 only for a lone btn1.
    assign w_digit = w_p0 | w_p1;
    assign w_bit   = ~w_p0;
    assign w_pass  = (w_ones >= CW'(MIN_ONES));
    assign w_clear = w_pe && (CLEAR_ON_ENTRY != 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= '0;
            r_count   <= '0;
            r_state   <= EMPTY;
            r_valid   <= 1'b0;
            r_pass    <= 1'b0;
            r_timer   <= '0;
        end else begin
            r_valid <= w_pe;
            if (w_pe) begin
                r_pass  <= w_pass;
                r_timer <= w_pass ? TW'(HOLD_CYCLES) : '0;
            end else if (r_timer != '0) begin
                r_timer <= r_timer - TW'(1);
            end

            // Evaluation above sees the pre-shift window; a clearing entry discards the digit.
            if (w_clear) begin
                r_pattern <= '0;
                r_count   <= '0;
                r_state   <= EMPTY;
            end else if (w_digit) begin
                r_pattern <= {r_pattern[WIDTH-2:0], w_bit};
                case (r_state)
                    EMPTY: begin
                        r_count <= CW'(1);
                        r_state <= PARTIAL;
                    end
                    PARTIAL: begin
                        r_count <= r_count + CW'(1);
                        if (r_count == CW'(WIDTH - 1)) begin
                            r_state <= FULL;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.pattern      = r_pattern;
    assign bus.digit_count  = r_count;
    assign bus.ones_count   = w_ones;
    assign bus.result_valid = r_valid;
    assign bus.result_pass  = r_pass;
    assign bus.led_light    = (r_timer != '0);

endmodule

// File: tb/tb_seq_entry_checker.sv
// Self-checking bench: two checkers (clear-on-entry off / on) share one button stimulus
// and are compared every cycle against a latency-based behavioural model.
module tb_seq_entry_checker;

    localparam int WIDTH    = 4;
    localparam int MIN_ONES = 2;
    localparam int HOLD     = 8;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic b0_n = 1'b1;
    logic b1_n = 1'b1;
    logic be_n = 1'b1;

    always #5 clk = ~clk;

    seq_entry_checker_if #(.WIDTH(WIDTH)) bus0 ();
    seq_entry_checker_if #(.WIDTH(WIDTH)) bus1 ();

    assign bus0.btn0_n      = b0_n;
    assign bus0.btn1_n      = b1_n;
    assign bus0.btn_entry_n = be_n;
    assign bus1.btn0_n      = b0_n;
    assign bus1.btn1_n      = b1_n;
    assign bus1.btn_entry_n = be_n;

    seq_entry_checker #(.WIDTH(WIDTH), .MIN_ONES(MIN_ONES), .HOLD_CYCLES(HOLD), .CLEAR_ON_ENTRY(0))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    seq_entry_checker #(.WIDTH(WIDTH), .MIN_ONES(MIN_ONES), .HOLD_CYCLES(HOLD), .CLEAR_ON_ENTRY(1))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pin that reads 0 at edge k after reading 1 at edge k-1 takes effect at edge k+3.
    int       m_pat   [2];
    int       m_cnt   [2];
    int       m_valid [2];
    int       m_pass  [2];
    int       m_timer [2];
    bit       m_live = 1'b0;
    bit [4:0] h0, h1, he;

    always @(posedge clk) begin
        bit p0, p1, pe;
        int ones;
        if (rst) begin
            h0 = '1; h1 = '1; he = '1;
            for (int d = 0; d < 2; d++) begin
                m_pat[d] = 0; m_cnt[d] = 0; m_valid[d] = 0; m_pass[d] = 0; m_timer[d] = 0;
            end
            m_live = 1'b1;
        end else begin
            h0 = {h0[3:0], b0_n};
            h1 = {h1[3:0], b1_n};
            he = {he[3:0], be_n};
            p0 = h0[4] && !h0[3];
            p1 = h1[4] && !h1[3];
            pe = he[4] && !he[3];
            for (int d = 0; d < 2; d++) begin
                if (pe) begin
                    ones        = $countones(m_pat[d]);
                    m_valid[d]  = 1;
                    m_pass[d]   = (ones >= MIN_ONES) ? 1 : 0;
                    m_timer[d]  = m_pass[d] ? HOLD : 0;
                end else begin
                    m_valid[d] = 0;
                    if (m_timer[d] > 0) m_timer[d]--;
                end
                if (pe && d == 1) begin
                    m_pat[d] = 0;
                    m_cnt[d] = 0;
                end else if (p0 || p1) begin
                    m_pat[d] = ((m_pat[d] << 1) | (p0 ? 0 : 1)) & ((1 << WIDTH) - 1);
                    if (m_cnt[d] < WIDTH) m_cnt[d]++;
                end
            end
        end
    end

    task automatic cmp(input int d, input logic [31:0] pat, input logic [31:0] cnt,
                       input logic [31:0] ones, input logic [31:0] v, input logic [31:0] ps,
                       input logic [31:0] led);
        check($sformatf("d%0d_pattern", d),      pat,  m_pat[d]);
        check($sformatf("d%0d_digit_count", d),  cnt,  m_cnt[d]);
        check($sformatf("d%0d_ones_count", d),   ones, $countones(m_pat[d]));
        check($sformatf("d%0d_result_valid", d), v,    m_valid[d]);
        check($sformatf("d%0d_result_pass", d),  ps,   m_pass[d]);
        check($sformatf("d%0d_led_light", d),    led,  (m_timer[d] > 0) ? 1 : 0);
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            cmp(0, bus0.pattern, bus0.digit_count, bus0.ones_count,
                bus0.result_valid, bus0.result_pass, bus0.led_light);
            cmp(1, bus1.pattern, bus1.digit_count, bus1.ones_count,
                bus1.result_valid, bus1.result_pass, bus1.led_light);
        end
    end

    task automatic press(input bit d0, input bit d1, input bit de);
        @(negedge clk);
        b0_n = ~d0; b1_n = ~d1; be_n = ~de;
        repeat (3) @(negedge clk);
        b0_n = 1'b1; b1_n = 1'b1; be_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic digit(input bit v);
        press(~v, v, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic entry_measure(output int vc, output int lc);
        vc = 0; lc = 0;
        @(negedge clk);
        be_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) be_n = 1'b1;
            vc += int'(bus0.result_valid);
            lc += int'(bus0.led_light);
        end
    endtask

    initial begin
        int vc, lc;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_pattern", bus0.pattern, 0);
        check("reset_count",   bus0.digit_count, 0);
        check("reset_pass",    bus0.result_pass, 0);
        check("reset_led",     bus0.led_light, 0);
        check("reset_valid",   bus1.result_valid, 0);

        // 1,0,1,1 fills the window; a passing entry holds the LED for HOLD cycles.
        digit(1); digit(0); digit(1); digit(1);
        check("fill_pattern", bus0.pattern, 4'b1011);
        check("fill_count",   bus0.digit_count, 4);
        check("fill_ones",    bus0.ones_count, 3);
        entry_measure(vc, lc);
        check("pass_valid_pulses", vc, 1);
        check("pass_led_cycles",   lc, HOLD);
        check("pass_result",       bus0.result_pass, 1);
        check("clr_pattern",       bus1.pattern, 0);
        check("clr_count",         bus1.digit_count, 0);
        check("clr_pass",          bus1.result_pass, 1);

        // 1,0,0,0 has a single one: fail, LED never lights.
        do_reset();
        digit(1); digit(0); digit(0); digit(0);
        entry_measure(vc, lc);
        check("fail_valid_pulses", vc, 1);
        check("fail_led_cycles",   lc, 0);
        check("fail_result",       bus0.result_pass, 0);

        // Saturation and oldest-bit discard, then one shift for a long hold.
        digit(1); digit(1); digit(1); digit(1);
        check("sat_count_a", bus0.digit_count, 4);
        digit(0); digit(0);
        check("shift_pattern", bus0.pattern, 4'b1100);
        check("sat_count_b",   bus0.digit_count, 4);
        @(negedge clk);
        b1_n = 1'b0;
        repeat (50) @(negedge clk);
        b1_n = 1'b1;
        repeat (5) @(negedge clk);
        check("long_hold_pattern", bus0.pattern, 4'b1001);
        check("long_hold_count",   bus0.digit_count, 4);

        // Pass at exactly MIN_ONES, then three 0s and a failing entry kill the hold early.
        @(negedge clk);
        be_n = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 9)  check("hold_led_before_fail", bus0.led_light, 1);
            if (i == 10) check("hold_led_killed",      bus0.led_light, 0);
            case (i)
                1: begin be_n = 1'b1; b0_n = 1'b0; end
                2: b0_n = 1'b1;
                3: b0_n = 1'b0;
                4: b0_n = 1'b1;
                5: b0_n = 1'b0;
                6: begin b0_n = 1'b1; be_n = 1'b0; end
                7: be_n = 1'b1;
                default: ;
            endcase
        end
        check("refail_pass",    bus0.result_pass, 0);
        check("refail_pattern", bus0.pattern, 4'b1000);
        check("refail_pattern_clr", bus1.pattern, 0);

        // Same-cycle collisions: btn0 beats btn1; entry sees the pre-shift window.
        do_reset();
        press(1'b1, 1'b1, 1'b0);
        check("collide_pattern", bus0.pattern, 0);
        check("collide_count",   bus0.digit_count, 1);
        digit(1);
        check("pre_entry_pattern", bus0.pattern, 4'b0001);
        press(1'b0, 1'b1, 1'b1);
        check("same_cycle_pass",    bus0.result_pass, 0);
        check("same_cycle_pattern", bus0.pattern, 4'b0011);
        check("same_cycle_count",   bus0.digit_count, 3);
        check("same_cycle_clr_pattern", bus1.pattern, 0);
        check("same_cycle_clr_count",   bus1.digit_count, 0);

        // Clear-on-entry pass, then reset mid-hold drops the LED at once.
        do_reset();
        digit(1); digit(1);
        @(negedge clk);
        be_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 3) be_n = 1'b1;
            if (i == 5) begin
                check("clr1_pass",    bus1.result_pass, 1);
                check("clr1_pattern", bus1.pattern, 0);
                check("clr1_count",   bus1.digit_count, 0);
                check("clr1_led_on",  bus1.led_light, 1);
                check("nclr_pattern", bus0.pattern, 4'b0011);
                rst = 1'b1;
            end
            if (i == 6) begin
                check("rst_hold_led0", bus0.led_light, 0);
                check("rst_hold_led1", bus1.led_light, 0);
                rst = 1'b0;
            end
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
